// File: rtl/gray_conv_arbiter.sv
// Four-requester round-robin arbiter that converts the winner's operand binary-to-gray.
// Define GRAY_DECODE_EN to add a per-requester mode input selecting gray-to-binary instead.
module gray_conv_arbiter #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] b_in,
`ifdef GRAY_DECODE_EN
  input  logic [3:0]     mode,
`endif
  output logic [3:0]     gnt,
  output logic [1:0]     gnt_id,
  output logic [W-1:0]   g_out,
  output logic           valid,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     ptr_reg, ptr_next;
  logic [1:0]     id_reg, id_next;
  logic [W-1:0]   op_reg, op_next;
  logic [W-1:0]   g_reg, g_next;
  logic [3:0]     rot;
  logic [1:0]     off;
  logic [1:0]     win;
  logic           found;
  logic [W-1:0]   enc_val;
`ifdef GRAY_DECODE_EN
  logic           dec_reg, dec_next;
  logic [W-1:0]   dec_val;
`endif

  // rot[k] is the request of the requester k places after the pointer
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot[gi] = req[ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    off   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = 2'(k);
      end
    end
  end

  assign win     = ptr_reg + off;
  assign enc_val = op_reg ^ (op_reg >> 1);

`ifdef GRAY_DECODE_EN
  // Each binary bit is the XOR of all gray bits at or above it
  generate
    for (gi = 0; gi < W; gi++) begin : g_dec
      assign dec_val[gi] = ^op_reg[W-1:gi];
    end
  endgenerate
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    op_next    = op_reg;
    g_next     = g_reg;
`ifdef GRAY_DECODE_EN
    dec_next   = dec_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          id_next    = win;
          op_next    = b_in[win*W +: W];
`ifdef GRAY_DECODE_EN
          dec_next   = mode[win];
`endif
          state_next = CONV;
        end
      end
      CONV: begin
`ifdef GRAY_DECODE_EN
        g_next     = dec_reg ? dec_val : enc_val;
`else
        g_next     = enc_val;
`endif
        state_next = DONE;
      end
      DONE: begin
        ptr_next   = id_reg + 2'd1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      id_reg    <= 2'd0;
      op_reg    <= '0;
      g_reg     <= '0;
`ifdef GRAY_DECODE_EN
      dec_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      op_reg    <= op_next;
      g_reg     <= g_next;
`ifdef GRAY_DECODE_EN
      dec_reg   <= dec_next;
`endif
    end
  end

  // Strobes decode straight from the state register so reset clears them at once
  assign gnt    = (state_reg == CONV) ? (4'b0001 << id_reg) : 4'b0000;
  assign valid  = (state_reg == DONE);
  assign busy   = (state_reg != IDLE);
  assign gnt_id = id_reg;
  assign g_out  = g_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed, table-driven bench for gray_conv_arbiter (W=4); mode tests run when GRAY_DECODE_EN is set.
module tb_gray_conv_arbiter;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] b_in;
  logic [3:0]     gnt;
  logic [1:0]     gnt_id;
  logic [W-1:0]   g_out;
  logic           valid;
  logic           busy;
`ifdef GRAY_DECODE_EN
  logic [3:0]     mode;
`endif

  int checks = 0;
  int errors = 0;

  gray_conv_arbiter #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .b_in   (b_in),
`ifdef GRAY_DECODE_EN
    .mode   (mode),
`endif
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .g_out  (g_out),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] ops;
    logic [1:0]  id;
    logic [3:0]  g;
  } vec_t;

  vec_t       tbl [19];
  logic [3:0] gray_tab [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; covers sampling, CONV, DONE and return to IDLE.
  task automatic serve(input string tag, input logic [3:0] r, input logic [15:0] ops,
                       input logic [3:0] hold, input logic [1:0] id, input logic [3:0] g);
    req  = r;
    b_in = ops;
    @(negedge clk);
    chk({tag, "_conv_gnt"}, 16'(gnt), 16'(4'b0001 << id));
    chk({tag, "_conv_id"}, 16'(gnt_id), 16'(id));
    chk({tag, "_conv_valid"}, 16'(valid), 16'd0);
    req  = hold;
    b_in = ~ops;
    @(negedge clk);
    chk({tag, "_done_valid"}, 16'(valid), 16'd1);
    chk({tag, "_done_gout"}, 16'(g_out), 16'(g));
    chk({tag, "_done_gnt"}, 16'(gnt), 16'd0);
    chk({tag, "_done_busy"}, 16'(busy), 16'd1);
    @(negedge clk);
    chk({tag, "_idle_valid"}, 16'(valid), 16'd0);
    chk({tag, "_idle_busy"}, 16'(busy), 16'd0);
    chk({tag, "_idle_hold"}, 16'(g_out), 16'(g));
    $display("serve %s req=%b id=%0d g_out=%b", tag, r, gnt_id, g_out);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    tbl[0] = '{req: 4'b0001, ops: 16'h0005, id: 2'd0, g: 4'b0111};
    for (int v = 0; v < 16; v++)
      tbl[1 + v] = '{req: 4'b0100, ops: 16'(v) << 8, id: 2'd2, g: gray_tab[v]};
    tbl[17] = '{req: 4'b1001, ops: 16'hA003, id: 2'd3, g: 4'b1111};
    tbl[18] = '{req: 4'b1001, ops: 16'hA003, id: 2'd0, g: 4'b0010};

    rst  = 1'b1;
    req  = 4'b0000;
    b_in = '0;
`ifdef GRAY_DECODE_EN
    mode = 4'b0000;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 16'(gnt), 16'd0);
    chk("rst_id", 16'(gnt_id), 16'd0);
    chk("rst_gout", 16'(g_out), 16'd0);
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_noreq_busy", 16'(busy), 16'd0);

    for (int i = 0; i < 19; i++)
      serve($sformatf("vec%0d", i), tbl[i].req, tbl[i].ops, 4'b0000, tbl[i].id, tbl[i].g);

    // Reset while in CONV aborts the service
    req  = 4'b0010;
    b_in = 16'h00C0;
    @(negedge clk);
    chk("abort_conv_gnt", 16'(gnt), 16'b0010);
    req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("abort_gout", 16'(g_out), 16'd0);
    chk("abort_gnt", 16'(gnt), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_valid", 16'(valid), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_novalid", 16'(valid), 16'd0);
    serve("after_abort", 4'b0010, 16'h0070, 4'b0000, 2'd1, 4'b0100);

    // All requesters held: strict rotation from 0, one service every 3 cycles
    do_reset();
    serve("fair0", 4'b1111, 16'h962F, 4'b1111, 2'd0, 4'b1000);
    serve("fair1", 4'b1111, 16'h962F, 4'b1111, 2'd1, 4'b0011);
    serve("fair2", 4'b1111, 16'h962F, 4'b1111, 2'd2, 4'b0101);
    serve("fair3", 4'b1111, 16'h962F, 4'b1111, 2'd3, 4'b1101);
    serve("fair4", 4'b1111, 16'h962F, 4'b0000, 2'd0, 4'b1000);

`ifdef GRAY_DECODE_EN
    do_reset();
    mode = 4'b0010;
    serve("decode", 4'b0010, 16'h0080, 4'b0000, 2'd1, 4'b1111);
    mode = 4'b0000;
    serve("encode", 4'b0010, 16'h0080, 4'b0000, 2'd1, 4'b1100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter W, default 4, operand and result width in bits; W SHALL be at least 2.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req  in  4  per-requester conversion request, bit i = requester i.
REQ-006 b_in  in  4*W  packed operands; requester i occupies [W*i+W-1 : W*i].
REQ-007 gnt  out  4  one-hot grant, high for exactly one cycle per service.
REQ-008 gnt_id  out  2  index of the requester currently or last served.
REQ-009 g_out  out  W  registered conversion result.
REQ-010 valid  out  1  one-cycle pulse qualifying g_out.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, CONV and DONE.
REQ-013 IDLE with req==0: SHALL stay in IDLE.
REQ-014 IDLE with req!=0: SHALL pick the winner i by round-robin, latch the operand for requester i, set gnt_id=i and go to CONV.
REQ-015 Round-robin search SHALL test ptr, ptr+1, ptr+2, ptr+3 (mod 4) and choose the first requester with req set.
REQ-016 CONV: gnt[i] SHALL be 1 for this single cycle; g_out SHALL load latched ^ (latched >> 1); then go to DONE.
REQ-017 DONE: valid SHALL be 1 for this single cycle; ptr SHALL become (i+1) mod 4; then go to IDLE.
REQ-018 Latency SHALL be 2 cycles from the edge that samples req in IDLE to valid high; peak throughput SHALL be one service per 3 cycles.
REQ-019 Operand changes or req deassertion after the IDLE sampling edge SHALL NOT affect the current result.
REQ-020 A requester SHALL hold req until it sees its gnt bit. A req still high after gnt SHALL be treated as a new request.
REQ-021 g_out and gnt_id SHALL hold their values until the next CONV.
REQ-022 gnt SHALL be 0 and valid SHALL be 0 in all states other than CONV and DONE respectively.

Reset
REQ-023 rst high SHALL immediately force state=IDLE, ptr=0, gnt=0, gnt_id=0, g_out=0, valid=0 and busy=0, independent of clk.
REQ-024 Reset asserted in CONV or DONE SHALL abort the service with no valid pulse. After reset, arbitration SHALL restart at requester 0.

Configuration
REQ-025 The macro GRAY_DECODE_EN SHALL control bidirectional conversion.
REQ-026 With GRAY_DECODE_EN defined, the block SHALL add port mode (in, 4), where bit i=1 selects gray-to-binary for requester i; mode[i] SHALL be latched together with the operand.
REQ-027 The gray-to-binary result SHALL be out[W-1]=x[W-1] and out[k]=out[k+1]^x[k] for k<W-1, registered in CONV with the same latency as REQ-018.
REQ-028 Without GRAY_DECODE_EN, the mode port SHALL be absent and every request SHALL be binary-to-gray.

Verification
REQ-029 Single request: req=0001, operand0=4'd5 -> gnt=0001 one cycle after sampling; valid pulse 2 cycles after sampling with g_out=4'b0111; busy high for 2 cycles.
REQ-030 Exhaustive: requester 2, operands 0..15 in turn -> g_out = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
REQ-031 Fairness: req=1111 held from reset -> grant order 0,1,2,3,0, with valid spaced every 3 cycles.
REQ-032 Wrap-around: after serving requester 2, req=1001 -> requester 3 served first, then requester 0.
REQ-033 Reset mid-operation: rst asserted in CONV -> no valid pulse, g_out=0, state IDLE; the next req=0010 is served with normal latency.
REQ-034 With GRAY_DECODE_EN: mode[1]=1, operand1=4'b1000 -> g_out=4'b1111; mode[1]=0, same operand -> g_out=4'b1100.
